// File: rtl/tile_pkg.sv
// tile_pkg: shared types and constants for the tile blitter pixel stage
package tile_pkg;
  typedef logic [8:0] color_t;
  localparam color_t KEY_COLOR = 9'd391;
  localparam int TILE_W = 32;
  localparam int TILE_H = 24;
  typedef enum logic {SHOW, HIDE} blink_state_t;
endpackage

// File: rtl/tile_blitter_if.sv
// tile_blitter_if: scan-coordinate request and composited pixel result
interface tile_blitter_if;
  import tile_pkg::*;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic pix_valid;
  color_t pix_color;
  logic pix_hit;
  logic pix_out_valid;
  modport master(output draw_x, draw_y, pix_valid, input pix_color, pix_hit, pix_out_valid);
  modport slave(input draw_x, draw_y, pix_valid, output pix_color, pix_hit, pix_out_valid);
endinterface

// File: rtl/tile_blitter_blink_ctrl.sv
// blink_ctrl: frame counter and SHOW/HIDE toggle for sprite blinking
module blink_ctrl import tile_pkg::*; #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic bl_l,
  output logic show
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  blink_state_t state_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge Clk)
    if (Reset || !bl_l) begin
      state_q <= SHOW;
      cnt_q <= '0;
    end else if (frame_start) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_q <= '0;
        state_q <= state_q == SHOW ? HIDE : SHOW;
      end else
        cnt_q <= cnt_q + CW'(1);
    end
  // Dropping the blink request shows the sprite at once, not one cycle later
  assign show = !bl_l || state_q == SHOW;
endmodule

// File: rtl/tile_blitter.sv
// tile_blitter: two-stage pipeline compositing one latched sprite tile at scan coordinates
module tile_blitter #(
  parameter int TILE_H = tile_pkg::TILE_H,
  parameter int TILE_W = tile_pkg::TILE_W,
  parameter logic [8:0] KEY_COLOR = tile_pkg::KEY_COLOR,
  parameter int BLINK_FRAMES = 30
) (
  input logic Clk,
  input logic Reset,
  input logic [9:0] tile [0:TILE_H-1][0:TILE_W-1],
  input logic frame_start,
  input logic [9:0] pos_x,
  input logic [9:0] pos_y,
  input logic enable,
  input logic blink_en,
  tile_blitter_if.slave pix
);
  import tile_pkg::*;
  localparam int RW = $clog2(TILE_H);
  localparam int CW = $clog2(TILE_W);
  logic [9:0] x_l_q, x_l_d, y_l_q, y_l_d;
  logic en_l_q, en_l_d, bl_l_q, bl_l_d, show;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic in_q, in_d, vis_q, vis_d, v1_q, v1_d;
  logic in_x, in_y;
  color_t c, color_q, color_d;
  logic hit_q, hit_d, v2_q, v2_d;
  blink_ctrl #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .bl_l(bl_l_q), .show(show)
  );
  // Zero-extended 11-bit bounds keep a tile near x=1023 clipped instead of wrapping
  always_comb begin
    x_l_d = frame_start ? pos_x : x_l_q;
    y_l_d = frame_start ? pos_y : y_l_q;
    en_l_d = frame_start ? enable : en_l_q;
    bl_l_d = frame_start ? blink_en : bl_l_q;
    in_x = {1'b0, pix.draw_x} >= {1'b0, x_l_q} && {1'b0, pix.draw_x} < {1'b0, x_l_q} + 11'(TILE_W);
    in_y = {1'b0, pix.draw_y} >= {1'b0, y_l_q} && {1'b0, pix.draw_y} < {1'b0, y_l_q} + 11'(TILE_H);
    in_d = in_x && in_y;
    row_d = in_d ? RW'(pix.draw_y - y_l_q) : '0;
    col_d = in_d ? CW'(pix.draw_x - x_l_q) : '0;
    vis_d = en_l_q && show;
    v1_d = pix.pix_valid;
    c = tile[row_q][col_q][8:0];
    hit_d = v1_q && in_q && vis_q && c != KEY_COLOR;
    color_d = hit_d ? c : '0;
    v2_d = v1_q;
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      x_l_q <= '0;
      y_l_q <= '0;
      en_l_q <= 1'b0;
      bl_l_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      in_q <= 1'b0;
      vis_q <= 1'b0;
      v1_q <= 1'b0;
      color_q <= '0;
      hit_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      x_l_q <= x_l_d;
      y_l_q <= y_l_d;
      en_l_q <= en_l_d;
      bl_l_q <= bl_l_d;
      row_q <= row_d;
      col_q <= col_d;
      in_q <= in_d;
      vis_q <= vis_d;
      v1_q <= v1_d;
      color_q <= color_d;
      hit_q <= hit_d;
      v2_q <= v2_d;
    end
  assign pix.pix_color = color_q;
  assign pix.pix_hit = hit_q;
  assign pix.pix_out_valid = v2_q;
endmodule

// File: doc/tile_blitter.md
# tile_blitter

- Pixel-pipeline stage that consumes one 24×32 sprite tile array, such as the digit tiles, and composites it at a screen position.
- Takes the VGA scan coordinates and returns, two cycles later, the tile's 9-bit color index plus a hit flag.
- The background key color is treated as transparent.
- Sprite position and enable are latched once per frame; an optional frame-counted blink is included.
- Sits between the tile ROMs and the top-level color mux.

## Interface

Parameters:
- TILE_H, 24, tile rows
- TILE_W, 32, tile columns
- KEY_COLOR, 9'd391, transparent color index
- BLINK_FRAMES, 30, frames per blink half-period (≥1)

Ports:
- Clk  in  1  system clock; one clock domain
- Reset  in  1  synchronous, active-high
- tile  in  10 × [0:TILE_H-1][0:TILE_W-1]  tile color array; bit 9 ignored, bits [8:0] are the color index
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blank
- pos_x  in  10  tile left column (screen x)
- pos_y  in  10  tile top row (screen y)
- enable  in  1  draw request
- blink_en  in  1  blink request
- draw_x  in  10  current pixel x
- draw_y  in  10  current pixel y
- pix_valid  in  1  draw_x/draw_y valid this cycle
- pix_color  out  9  tile color when hit, else 0
- pix_hit  out  1  opaque tile pixel at this coordinate
- pix_out_valid  out  1  pix_valid delayed by 2

## Operation

- **Shadow latch.** On frame_start, latch pos_x, pos_y, enable and blink_en into x_l, y_l, en_l, bl_l. No other cycle changes them.
- **Blink FSM** (states SHOW, HIDE):
  - The frame counter counts frame_start pulses.
  - When bl_l=1 and the counter reaches BLINK_FRAMES-1 on a frame_start: the counter returns to 0 and the state toggles.
  - bl_l=0 forces SHOW and counter 0.
  - visible = en_l & (state==SHOW).
- **Stage 1** (registered):
  - dx = draw_x − x_l and dy = draw_y − y_l, computed in 11 bits.
  - inside = draw_x ≥ x_l & {1'b0,draw_x} < x_l+TILE_W & the same test for y.
  - All comparisons are zero-extended to 11 bits, so a tile placed near 1023 clips; it never wraps to column 0.
  - Register row=dy[4:0], col=dx[4:0], inside, visible, valid=pix_valid.
- **Stage 2** (registered):
  - c = tile[row][col][8:0].
  - pix_hit = valid & inside & visible & (c≠KEY_COLOR).
  - pix_color = pix_hit ? c : 0.
  - pix_out_valid = valid.
- When stage-1 inside=0, row/col are don't-care. The tile must not be indexed out of range; use the clamped index 0.
- pix_valid=0 produces pix_hit=0 and pix_color=0 two cycles later.

## Timing

- Latency is exactly 2 cycles from draw_x/draw_y/pix_valid to the outputs. Throughput is one pixel per cycle, with no stalls.
- Reset values:
  - pix_color=0, pix_hit=0, pix_out_valid=0.
  - x_l=y_l=0, en_l=bl_l=0.
  - Blink state SHOW, counter 0.
  - Pipeline valid bits are cleared.
- Reset asserted mid-frame: outputs are 0 from the first cycle after Reset is sampled. After deassertion, nothing is drawn until the next frame_start.
- frame_start coincident with pix_valid: that pixel uses the old latched values. New values apply from the next cycle.
- frame_start during Reset is ignored.
- The blink toggle takes effect on the visibility of pixels entering stage 1 in the cycle after the frame_start that caused it.
- The tile input is sampled combinationally in stage 2. It must be stable for the whole frame.

## Structure

- Shared package tile_pkg holds:
  - color_t (logic [8:0]) and KEY_COLOR.
  - TILE_W and TILE_H.
  - The blink_state_t enum {SHOW, HIDE}.
- Sub-module blink_ctrl contains the frame counter and the SHOW/HIDE FSM. Its inputs are Clk, Reset, frame_start and bl_l; its output is show.
- The remainder (latch and two pipeline stages) is flat in tile_blitter.

## Test plan

- **Opaque pixel hit.** Tile[3][2]=430, tile[0][0]=391; frame_start with pos=(100,50), enable=1. Then draw (102,53) with pix_valid → 2 cycles later pix_hit=1, pix_color=430, pix_out_valid=1.
- **Key color and bounds.**
  - (100,50) → pix_hit=0, color 0 (key color).
  - (132,50) and (99,50) → pix_hit=0 (outside).
  - (131,73) → in-bounds lookup of tile[23][31].
- **Latch isolation.** Change pos_x to 200 mid-frame without frame_start → (102,53) still hits. After frame_start, (202,53) hits and (102,53) misses.
- **Right-edge clip.** pos_x=1010 → x=1015 maps to col 5. x=3 never hits: no wrap.
- **Blink.** BLINK_FRAMES=2, blink_en=1 → hits in frames 0–1 (after latch), none in frames 2–3, hits again in frames 4–5. Dropping blink_en restores SHOW on the next frame_start.
- **Reset mid-stream.** Assert Reset while hits are streaming → pix_hit, pix_color and pix_out_valid are 0 the next cycle. After release, no hits until frame_start re-latches enable=1.
